// File: rtl/dmem_line_ctrl.sv
// Line-granular data memory behind the D-cache: one line per access, ack_o pulses LATENCY cycles after acceptance.
// Requests are taken only in IDLE (a held enable_i simply waits); DMEM_ACCESS_STATS_EN adds read/write completion counters.
module dmem_line_ctrl #(
   parameter int LINE_W  = 256,
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              enable_i,
   input  logic              write_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o,
   output logic [31:0]       rd_cnt_o,
   output logic [31:0]       wr_cnt_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [LINE_W-1:0]   wdat;
   logic                wr;
   logic                done;
   logic                unused_addr_bits;

   logic [LINE_W-1:0]   memory [DEPTH];

   // Only the line-index bits of the byte address matter; offset and upper bits wrap away.
   assign unused_addr_bits = ^{addr_i[ADDR_W-1:5+IDX_W], addr_i[4:0]};

   // Completion edge: the array is touched and data_o loaded here, one cycle before ack_o rises.
   assign done = (state == BUSY) && (cnt == CNT_W'(1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         wdat   <= '0;
         wr     <= 1'b0;
         ack_o  <= 1'b0;
         data_o <= '0;
      end else begin
         ack_o <= (state == ACK);
         case (state)
            IDLE: begin
               if (enable_i) begin
                  idx   <= addr_i[5+IDX_W-1:5];
                  wdat  <= data_i;
                  wr    <= write_i;
                  cnt   <= CNT_W'(LATENCY - 1);
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (done) begin
                  state  <= ACK;
                  data_o <= wr ? wdat : memory[idx];
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // No reset on the array: contents survive reset, and reset forces IDLE so done cannot fire.
   always_ff @(posedge clk_i) begin
      if (done && wr) begin
         memory[idx] <= wdat;
      end
   end

`ifdef DMEM_ACCESS_STATS_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_cnt_o <= '0;
         wr_cnt_o <= '0;
      end else if (done) begin
         if (wr) begin
            wr_cnt_o <= wr_cnt_o + 32'd1;
         end else begin
            rd_cnt_o <= rd_cnt_o + 32'd1;
         end
      end
   end
`else
   assign rd_cnt_o = '0;
   assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Directed bench for dmem_line_ctrl at default geometry with LATENCY = 10.
module tb_dmem_line_ctrl;

   localparam int LAT = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  addr = '0;
   logic [255:0] data = '0;
   logic         en = 1'b0;
   logic         wr = 1'b0;
   logic         ack;
   logic [255:0] dout;
   logic [31:0]  rd_cnt;
   logic [31:0]  wr_cnt;

   int checks = 0;
   int errors = 0;

   dmem_line_ctrl #(
      .LINE_W  (256),
      .ADDR_W  (32),
      .DEPTH   (512),
      .LATENCY (LAT)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .addr_i   (addr),
      .data_i   (data),
      .enable_i (en),
      .write_i  (wr),
      .ack_o    (ack),
      .data_o   (dout),
      .rd_cnt_o (rd_cnt),
      .wr_cnt_o (wr_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] pre(input int i);
      logic [31:0] w;
      w = 32'hA5A5_0000 | 32'(i);
      return {8{w}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request from IDLE; lat = cycles from acceptance edge to first ack (0 on timeout).
   task automatic access(input logic [31:0] a, input logic [255:0] d, input logic w,
                         output logic [255:0] rdata, output int lat);
      addr = a; data = d; wr = w; en = 1'b1;
      tick();
      en = 1'b0;
      lat = 0;
      rdata = '0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (ack) begin
            lat = i;
            rdata = dout;
            break;
         end
      end
   endtask

   initial begin
      logic [255:0] p1, p2, p3, p4, rd, d1, d2, rnd;
      logic [31:0]  r;
      int lat, n, c1, c2;

      p1 = {8{32'hDEAD_BEEF}};
      p2 = {8{32'h0BAD_F00D}};
      p3 = {8{32'h1234_5678}};
      p4 = {8{32'hCAFE_0060}};

      // Reset state
      tick(); tick();
      chk("reset_ack", 256'(ack), 256'(0));
      chk("reset_data", dout, 256'(0));
      chk("reset_rd_cnt", 256'(rd_cnt), 256'(0));
      chk("reset_wr_cnt", 256'(wr_cnt), 256'(0));
      rst = 1'b1;
      for (int i = 0; i < 64; i++) dut.memory[i] = pre(i);
      dut.memory[0] = 256'h5;
      tick();

      // 1: read line 0, ack exactly LAT cycles after acceptance, then low
      access(32'h0000_0000, '0, 1'b0, rd, lat);
      chk("t1_latency", 256'(lat), 256'(LAT));
      chk("t1_data", rd, 256'h5);
      tick();
      chk("t1_ack_low", 256'(ack), 256'(0));

      // 2: write then read line 1
      access(32'h0000_0020, p1, 1'b1, rd, lat);
      chk("t2_wr_latency", 256'(lat), 256'(LAT));
      chk("t2_wr_dout", rd, p1);
      chk("t2_mem1", dut.memory[1], p1);
      chk("t2_mem0", dut.memory[0], 256'h5);
      chk("t2_mem2", dut.memory[2], pre(2));
      access(32'h0000_0020, '0, 1'b0, rd, lat);
      chk("t2_rd_data", rd, p1);

      // 3: write-back to line 32 then refill line 2 with enable held high
      addr = 32'h0000_0400; data = p2; wr = 1'b1; en = 1'b1;
      tick();
      addr = 32'h0000_0040; wr = 1'b0; data = '1;
      n = 0; c1 = 0; c2 = 0; d1 = '0; d2 = '0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c == 11) en = 1'b0;
         if (ack) begin
            n++;
            if (n == 1) begin c1 = c; d1 = dout; end
            else begin c2 = c; d2 = dout; end
         end
      end
      chk("t3_ack_count", 256'(n), 256'(2));
      chk("t3_first_ack", 256'(c1), 256'(LAT));
      chk("t3_spacing", 256'(c2 - c1), 256'(LAT + 1));
      chk("t3_wr_dout", d1, p2);
      chk("t3_rd_data", d2, pre(2));
      chk("t3_mem32", dut.memory[32], p2);

      // 4: inputs toggling during BUSY are ignored (read line 4, then write line 6)
      addr = 32'h0000_0080; wr = 1'b0; data = '0; en = 1'b1;
      tick();
      for (int i = 1; i <= 9; i++) begin
         r = $urandom();
         addr = (i % 2 == 1) ? 32'h0000_0020 : 32'h0000_00A0;
         wr = (i % 2 == 1);
         en = (i % 2 == 1);
         data = {8{r}};
         tick();
      end
      en = 1'b0;
      tick();
      chk("t4_rd_ack", 256'(ack), 256'(1));
      chk("t4_rd_data", dout, pre(4));
      tick();
      addr = 32'h0000_00C0; wr = 1'b1; data = p3; en = 1'b1;
      tick();
      for (int i = 1; i <= 9; i++) begin
         r = $urandom();
         rnd = {8{r}};
         addr = (i % 2 == 1) ? 32'h0000_0020 : 32'h0000_00A0;
         wr = (i % 2 == 0);
         en = (i % 2 == 1);
         data = rnd;
         tick();
      end
      en = 1'b0;
      tick();
      chk("t4_wr_ack", 256'(ack), 256'(1));
      chk("t4_mem6", dut.memory[6], p3);
      chk("t4_mem1", dut.memory[1], p1);
      chk("t4_mem5", dut.memory[5], pre(5));
      tick();

      // Index wraps modulo DEPTH; offset and upper address bits ignored
      access(32'h0000_401F, '0, 1'b0, rd, lat);
      chk("wrap_4000", rd, 256'h5);
      access(32'hFFFF_C040, '0, 1'b0, rd, lat);
      chk("wrap_upper", rd, pre(2));

      // 5: reset 3 cycles into a write to line 3
      addr = 32'h0000_0060; data = p4; wr = 1'b1; en = 1'b1;
      tick();
      en = 1'b0;
      tick(); tick(); tick();
      rst = 1'b0;
      #1;
      chk("t5_rst_ack", 256'(ack), 256'(0));
      chk("t5_rst_data", dout, 256'(0));
      chk("t5_rst_rd_cnt", 256'(rd_cnt), 256'(0));
      chk("t5_rst_wr_cnt", 256'(wr_cnt), 256'(0));
      tick(); tick();
      rst = 1'b1;
      n = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (ack) n++;
      end
      chk("t5_no_ack", 256'(n), 256'(0));
      chk("t5_mem3", dut.memory[3], pre(3));
      access(32'h0000_0060, '0, 1'b0, rd, lat);
      chk("t5_after_latency", 256'(lat), 256'(LAT));
      chk("t5_after_data", rd, pre(3));

      // 6: completion counters from a fresh reset
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      access(32'h0000_0000, '0, 1'b0, rd, lat);
      access(32'h0000_0140, p1, 1'b1, rd, lat);
      access(32'h0000_0020, '0, 1'b0, rd, lat);
      access(32'h0000_0160, p2, 1'b1, rd, lat);
      access(32'h0000_0140, '0, 1'b0, rd, lat);
      chk("t6_readback", rd, p1);
`ifdef DMEM_ACCESS_STATS_EN
      chk("t6_rd_cnt", 256'(rd_cnt), 256'(3));
      chk("t6_wr_cnt", 256'(wr_cnt), 256'(2));
`else
      chk("t6_rd_cnt", 256'(rd_cnt), 256'(0));
      chk("t6_wr_cnt", 256'(wr_cnt), 256'(0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
